sensor_debounce: RTL and testbench

Upstream conditioning stage for the line-follower motor FSM. Takes the three raw IR line sensors (front, left, right) and samples them on a prescaled tick. Each channel is filtered with a consecutive-sample stability counter. Outputs are clean, glitch-free sensor levels plus a one-cycle change strobe that the FSM consumes in place of the raw pins.

---
 rtl/sensor_pkg.sv | 12 +
 rtl/sensor_filter_ch.sv | 49 ++++
 rtl/sensor_debounce.sv | 88 ++++++++
 tb/tb_sensor_debounce.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared constants for the IR line-sensor path: channel indices and default timing.
package sensor_pkg;

  localparam int unsigned SENS_F = 2;
  localparam int unsigned SENS_L = 1;
  localparam int unsigned SENS_R = 0;
  localparam int unsigned SENS_N = 3;

  localparam int unsigned SAMPLE_DIV_DEF = 100;
  localparam int unsigned STABLE_CNT_DEF = 4;

endpackage

// File: rtl/sensor_filter_ch.sv
// Single-channel debounce: consecutive-sample stability counter plus filtered output flop.
module sensor_filter_ch #(
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sample,
  input  logic raw,
  output logic out,
  output logic flip
);

  localparam int unsigned CntW = $clog2(STABLE_CNT) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CNT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            out_q, out_d;

  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    flip  = 1'b0;
    if (sample) begin
      if (raw == out_q) begin
        // Any agreeing sample discards partial progress.
        cnt_d = '0;
      end else if (cnt_q == CntMax) begin
        out_d = raw;
        cnt_d = '0;
        flip  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/sensor_debounce.sv
// Sensor conditioning top: sample prescaler, per-channel debounce and change strobe.
// Define SENSOR_SYNC_EN to insert a 2-flop input synchronizer ahead of the filters.
module sensor_debounce
  import sensor_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_DEF,
  parameter int unsigned STABLE_CNT = STABLE_CNT_DEF,
  parameter int unsigned CNT_W      = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [SENS_N-1:0] raw_sensors,
  output logic [SENS_N-1:0] sensors_out,
  output logic              changed,
  output logic              sample_tick
);

  localparam logic [CNT_W-1:0] PrescMax = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0]  presc_q, presc_d;
  logic              tick_q, tick_d;
  logic              changed_q, changed_d;
  logic              sample;
  logic [SENS_N-1:0] filt_raw;
  logic [SENS_N-1:0] flip;

`ifdef SENSOR_SYNC_EN
  logic [SENS_N-1:0] sync1_q, sync2_q;

  // Synchronizer keeps running while en is low so no stale level is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_sensors;
      sync2_q <= sync1_q;
    end
  end

  assign filt_raw = sync2_q;
`else
  assign filt_raw = raw_sensors;
`endif

  assign sample = en && (presc_q == PrescMax);

  always_comb begin
    presc_d   = presc_q;
    tick_d    = 1'b0;
    changed_d = 1'b0;
    if (en) begin
      presc_d   = sample ? '0 : presc_q + 1'b1;
      tick_d    = sample;
      changed_d = |flip;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      tick_q    <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      changed_q <= changed_d;
    end
  end

  for (genvar i = 0; i < SENS_N; i++) begin : g_ch
    sensor_filter_ch #(
      .STABLE_CNT(STABLE_CNT)
    ) u_filter (
      .clk   (clk),
      .reset (reset),
      .sample(sample),
      .raw   (filt_raw[i]),
      .out   (sensors_out[i]),
      .flip  (flip[i])
    );
  end

  assign changed     = changed_q;
  assign sample_tick = tick_q;

endmodule

// File: tb/tb_sensor_debounce.sv
// Self-checking bench for sensor_debounce: cycle model feeds a scoreboard, plus directed checks.
module tb_sensor_debounce;

  localparam int unsigned SampleDiv = 4;
  localparam int unsigned StableCnt = 3;
  localparam int unsigned CntW      = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] raw_sensors;
  logic [2:0] sensors_out;
  logic       changed;
  logic       sample_tick;

  int checks = 0;
  int errors = 0;

  logic [4:0] sb[$];
  logic [4:0] got, exp;

  // Reference model state
  int         m_presc;
  int         m_cnt[3];
  logic [2:0] m_out;
  logic       m_chg, m_tick;
  logic [2:0] m_s1, m_s2;

  sensor_debounce #(
    .SAMPLE_DIV(SampleDiv),
    .STABLE_CNT(StableCnt),
    .CNT_W     (CntW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .raw_sensors(raw_sensors),
    .sensors_out(sensors_out),
    .changed    (changed),
    .sample_tick(sample_tick)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus, advance the model, push its expectation, cross the edge.
  task automatic cycle(input logic [2:0] r, input logic e, input logic rs);
    logic [2:0] filt;
    logic       smp, any;
    raw_sensors = r;
    en          = e;
    reset       = rs;
`ifdef SENSOR_SYNC_EN
    filt = m_s2;
`else
    filt = r;
`endif
    if (rs) begin
      m_presc = 0;
      m_cnt   = '{0, 0, 0};
      m_out   = 3'b000;
      m_chg   = 1'b0;
      m_tick  = 1'b0;
      m_s1    = 3'b000;
      m_s2    = 3'b000;
    end else begin
      m_s2 = m_s1;
      m_s1 = r;
      if (e) begin
        smp     = (m_presc == SampleDiv - 1);
        m_presc = smp ? 0 : m_presc + 1;
        any     = 1'b0;
        if (smp) begin
          for (int ch = 0; ch < 3; ch++) begin
            if (filt[ch] == m_out[ch]) begin
              m_cnt[ch] = 0;
            end else if (m_cnt[ch] + 1 >= StableCnt) begin
              m_out[ch] = filt[ch];
              m_cnt[ch] = 0;
              any       = 1'b1;
            end else begin
              m_cnt[ch] = m_cnt[ch] + 1;
            end
          end
        end
        m_tick = smp;
        m_chg  = any;
      end else begin
        m_tick = 1'b0;
        m_chg  = 1'b0;
      end
    end
    sb.push_back({m_out, m_chg, m_tick});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) cycle(3'b111, 1'b1, 1'b1);
      else       cycle(3'b000, 1'b1, 1'b0);
      exp = sb.pop_front();
      got = {sensors_out, changed, sample_tick};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_model cyc %0d: got %b want %b", i, got, exp);
      end
      checks++;
      if (got !== 5'b00000) begin
        errors++;
        $display("FAIL reset_zero cyc %0d: got %b want 00000", i, got);
      end
    end
  endtask

  task automatic test_step();
    int first_flip = -1;
    int pulses     = 0;
    for (int k = 2; k <= 14; k++) begin
      cycle(3'b100, 1'b1, 1'b0);
      exp = sb.pop_front();
      got = {sensors_out, changed, sample_tick};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL step_model edge %0d: got %b want %b", k, got, exp);
      end
      if (changed === 1'b1) pulses++;
      if (first_flip < 0 && sensors_out === 3'b100) first_flip = k;
    end
    checks++;
    if (first_flip != 3 * SampleDiv) begin
      errors++;
      $display("FAIL step_latency: got edge %0d want edge %0d", first_flip, 3 * SampleDiv);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL step_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    for (int rep = 0; rep < 4; rep++) begin
      for (int i = 0; i < 12; i++) begin
        cycle((i < 5) ? 3'b110 : 3'b100, 1'b1, 1'b0);
        exp = sb.pop_front();
        got = {sensors_out, changed, sample_tick};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL glitch_model rep %0d cyc %0d: got %b want %b", rep, i, got, exp);
        end
        if (changed === 1'b1) pulses++;
      end
    end
    checks++;
    if (pulses != 0 || sensors_out !== 3'b100) begin
      errors++;
      $display("FAIL glitch_hold: got out %b pulses %0d want out 100 pulses 0",
               sensors_out, pulses);
    end
  endtask

  task automatic test_simultaneous();
    int         pulses = 0;
    int         steps  = 0;
    logic [2:0] prev;
    prev = sensors_out;
    for (int i = 0; i < 16; i++) begin
      cycle(3'b101, 1'b1, 1'b0);
      exp = sb.pop_front();
      got = {sensors_out, changed, sample_tick};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL simul_model cyc %0d: got %b want %b", i, got, exp);
      end
      if (changed === 1'b1) pulses++;
      if (sensors_out !== prev) steps++;
      prev = sensors_out;
    end
    checks++;
    if (pulses != 1 || steps != 1 || sensors_out !== 3'b101) begin
      errors++;
      $display("FAIL simul_flip: got out %b pulses %0d steps %0d want out 101 pulses 1 steps 1",
               sensors_out, pulses, steps);
    end
  endtask

  task automatic test_en_freeze();
    int   n      = 0;
    int   frozen = 0;
    logic done   = 1'b0;
    for (int i = 0; i < 20 && m_cnt[1] != 2; i++) begin
      cycle(3'b111, 1'b1, 1'b0);
      exp = sb.pop_front();
      got = {sensors_out, changed, sample_tick};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL freeze_pre_model cyc %0d: got %b want %b", i, got, exp);
      end
    end
    for (int i = 0; i < 20; i++) begin
      cycle(3'b111, 1'b0, 1'b0);
      exp = sb.pop_front();
      got = {sensors_out, changed, sample_tick};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL freeze_model cyc %0d: got %b want %b", i, got, exp);
      end
      if (changed !== 1'b0 || sample_tick !== 1'b0 || sensors_out !== 3'b101) frozen++;
    end
    checks++;
    if (frozen != 0) begin
      errors++;
      $display("FAIL freeze_hold: got %0d disturbed cycles want 0", frozen);
    end
    for (int i = 1; i <= 2 * SampleDiv && !done; i++) begin
      cycle(3'b111, 1'b1, 1'b0);
      exp = sb.pop_front();
      got = {sensors_out, changed, sample_tick};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL freeze_post_model cyc %0d: got %b want %b", i, got, exp);
      end
      if (sensors_out === 3'b111) begin
        done = 1'b1;
        n    = i;
      end
    end
    checks++;
    if (!done || n > SampleDiv) begin
      errors++;
      $display("FAIL freeze_resume: got flip after %0d cycles (seen %b) want <= %0d",
               n, done, SampleDiv);
    end
  endtask

  task automatic test_reset_mid();
    int   n    = 0;
    logic done = 1'b0;
    for (int i = 0; i < 20 && m_cnt[2] != 2; i++) begin
      cycle(3'b010, 1'b1, 1'b0);
      exp = sb.pop_front();
      got = {sensors_out, changed, sample_tick};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rstmid_pre_model cyc %0d: got %b want %b", i, got, exp);
      end
    end
    cycle(3'b010, 1'b1, 1'b1);
    exp = sb.pop_front();
    got = {sensors_out, changed, sample_tick};
    checks++;
    if (got !== exp || got !== 5'b00000) begin
      errors++;
      $display("FAIL rstmid_reset: got %b want %b", got, exp);
    end
    for (int k = 1; k <= 20 && !done; k++) begin
      cycle(3'b010, 1'b1, 1'b0);
      exp = sb.pop_front();
      got = {sensors_out, changed, sample_tick};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rstmid_model edge %0d: got %b want %b", k, got, exp);
      end
      if (sensors_out === 3'b010) begin
        done = 1'b1;
        n    = k;
      end
    end
    checks++;
    if (!done || n != 3 * SampleDiv) begin
      errors++;
      $display("FAIL rstmid_latency: got edge %0d (seen %b) want edge %0d",
               n, done, 3 * SampleDiv);
    end
  endtask

  initial begin
    reset       = 1'b1;
    en          = 1'b1;
    raw_sensors = 3'b000;
    test_reset();
    test_step();
    test_glitch();
    test_simultaneous();
    test_en_freeze();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
